// File: rtl/cpu_exec_unit.sv
// Mini-CPU execute stage: 2-cycle simple ops and an optional 16-step shift-add MUL.
// Define CPU_EXEC_MUL_EN to build the multiplier; otherwise MUL returns opA without write-back.
module cpu_exec_unit #(
  parameter int W    = 16,
  parameter int IMMW = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      opcode,
  input  logic [W-1:0]    opA,
  input  logic [W-1:0]    opB,
  input  logic [IMMW-1:0] imm,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    result,
  output logic            we,
  output logic            ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_t;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_ADDI  = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_SUBI  = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  state_t       state;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q, imm_q;
  logic [W-1:0] imm_s;
  logic [W-1:0] rhs, sum_res, dif_res, alu_res;
  logic         alu_we, alu_ovf;

  assign imm_s = {{(W-IMMW){imm[IMMW-1]}}, imm};

  // Single-pass ALU on the latched operands; MUL and DISPLAY fall through to opA, no write.
  always_comb begin
    rhs     = (op_q == OP_ADD || op_q == OP_SUB) ? b_q : imm_q;
    sum_res = a_q + rhs;
    dif_res = a_q - rhs;
    alu_res = a_q;
    alu_we  = 1'b0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_LOAD: begin
        alu_res = imm_q;
        alu_we  = 1'b1;
      end
      OP_ADD, OP_ADDI: begin
        alu_res = sum_res;
        alu_we  = 1'b1;
        alu_ovf = (a_q[W-1] == rhs[W-1]) && (sum_res[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = dif_res;
        alu_we  = 1'b1;
        alu_ovf = (a_q[W-1] != rhs[W-1]) && (dif_res[W-1] != a_q[W-1]);
      end
      OP_CLEAR: alu_res = '0;
      default: alu_res = a_q;
    endcase
  end

`ifdef CPU_EXEC_MUL_EN
  localparam int CW = $clog2(W) + 1;
  localparam logic [2*W-1:0] MAX_POS     = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] MAX_NEG_MAG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

  logic [W-1:0]   mcand, mplier;
  logic [2*W-1:0] acc, prod;
  logic [W:0]     partial;
  logic [CW-1:0]  iter;
  logic           neg, mul_ovf;

  // Magnitudes are unsigned, so -32768 becomes a plain 0x8000 multiplicand.
  always_comb begin
    partial = {1'b0, acc[2*W-1:W]} + {1'b0, (mplier[0] ? mcand : {W{1'b0}})};
    prod    = neg ? -acc : acc;
    mul_ovf = neg ? (acc > MAX_NEG_MAG) : (acc > MAX_POS);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      we     <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
`ifdef CPU_EXEC_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      iter   <= '0;
      neg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= opcode;
            a_q   <= opA;
            b_q   <= opB;
            imm_q <= imm_s;
            busy  <= 1'b1;
`ifdef CPU_EXEC_MUL_EN
            mcand  <= opA[W-1] ? -opA : opA;
            mplier <= imm_s[W-1] ? -imm_s : imm_s;
            neg    <= opA[W-1] ^ imm_s[W-1];
            acc    <= '0;
            iter   <= '0;
            state  <= (opcode == OP_MUL) ? MULT : EXEC;
`else
            state  <= EXEC;
`endif
          end
        end
        EXEC: begin
          result <= alu_res;
          we     <= alu_we;
          ovf    <= alu_ovf;
          done   <= 1'b1;
          state  <= DONE;
        end
        MULT: begin
`ifdef CPU_EXEC_MUL_EN
          // One extra cycle after the last shift applies the sign and publishes the result.
          if (iter == CW'(W)) begin
            result <= prod[W-1:0];
            ovf    <= mul_ovf;
            we     <= 1'b1;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc    <= {partial, acc[W-1:1]};
            mplier <= mplier >> 1;
            iter   <= iter + 1'b1;
          end
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
